// File: rtl/bus_master_if.sv
// -----------------------------------------------------------------------------
// bus_master_if
//   Bridges a simple core command interface onto a request/grant arbitrated
//   bus with an address strobe and a slave ready handshake. One command is
//   in flight at a time. The command is accepted in IDLE, the bus is
//   requested, and one address-strobe cycle is issued after the grant. The
//   block then waits for the slave's ready and returns a single-cycle
//   completion pulse.
//
//   Optional feature (macro BUS_TIMEOUT_EN): abort a transaction that has
//   waited TIMEOUT_CYCLES consecutive cycles for ready, and flag it with
//   rsp_err. When the macro is undefined, rsp_err is tied low and no
//   counter exists.
//
// Parameters
//   ADDR_W          word-address width
//   DATA_W          data width
//   TIMEOUT_CYCLES  WAIT cycles allowed before abort (BUS_TIMEOUT_EN only)
//
// Ports
//   clk, rst               clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready    command handshake (cmd_rw: 1 = read)
//   cmd_addr, cmd_wr_data  command address / write data
//   rsp_valid              one-cycle completion pulse
//   rsp_rd_data, rsp_err   read data, timeout-abort flag
//   bus_req_/bus_grnt_     arbiter request/grant (active-low)
//   bus_as_                address strobe (active-low)
//   bus_rw, bus_addr       bus direction (1 = read) and address
//   bus_wr_data            bus write data
//   bus_rd_data, bus_rdy_  slave read data, slave ready (active-low)
// -----------------------------------------------------------------------------
module bus_master_if #(
  parameter int ADDR_W         = 30,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wr_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rd_data,
  output logic              rsp_err,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  // A zero timeout would abort every transaction before the slave could ever
  // answer; refuse to elaborate in that case.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("bus_master_if: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    WAIT   = 2'd3
  } state_e;

  state_e              state_q, state_d;

  // Command captured at accept time; bus outputs are loaded from here once
  // the grant arrives.
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  // Registered outputs (active-low bus controls carry an _n in the name).
  logic                cmd_ready_q, cmd_ready_d;
  logic                bus_req_n_q, bus_req_n_d;
  logic                bus_as_n_q, bus_as_n_d;
  logic                bus_rw_q, bus_rw_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wr_data_q, bus_wr_data_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rd_data_q, rsp_rd_data_d;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                rsp_err_q, rsp_err_d;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic. Every output is computed for the state
  // being entered, so the flops present it during that state.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    rw_d          = rw_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cmd_ready_d   = cmd_ready_q;
    bus_req_n_d   = bus_req_n_q;
    bus_as_n_d    = bus_as_n_q;
    bus_rw_d      = bus_rw_q;
    bus_addr_d    = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    rsp_valid_d   = 1'b0;
    rsp_rd_data_d = rsp_rd_data_q;
`ifdef BUS_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    rsp_err_d     = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          rw_d        = cmd_rw;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wr_data;
          cmd_ready_d = 1'b0;
          bus_req_n_d = 1'b0;
          state_d     = REQ;
        end
      end

      // Slave ready is deliberately not looked at here or in ACCESS.
      REQ: begin
        if (!bus_grnt_) begin
          bus_as_n_d    = 1'b0;
          bus_rw_d      = rw_q;
          bus_addr_d    = addr_q;
          bus_wr_data_d = wdata_q;
          state_d       = ACCESS;
        end
      end

      ACCESS: begin
        bus_as_n_d = 1'b1;
`ifdef BUS_TIMEOUT_EN
        tmo_cnt_d  = '0;
`endif
        state_d    = WAIT;
      end

      // Grant is ignored; the bus stays requested until completion.
      // Ready is tested first so a same-cycle ready beats the timeout.
      WAIT: begin
        if (!bus_rdy_) begin
          rsp_valid_d = 1'b1;
          if (rw_q) rsp_rd_data_d = bus_rd_data;
          bus_req_n_d = 1'b1;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
`ifdef BUS_TIMEOUT_EN
        else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // This WAIT cycle is the TIMEOUT_CYCLES-th without ready.
          tmo_cnt_d     = CNT_W'(TIMEOUT_CYCLES);
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_rd_data_d = '0;
          bus_req_n_d   = 1'b1;
          cmd_ready_d   = 1'b1;
          state_d       = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      rw_q          <= 1'b1;
      addr_q        <= '0;
      wdata_q       <= '0;
      cmd_ready_q   <= 1'b1;
      bus_req_n_q   <= 1'b1;
      bus_as_n_q    <= 1'b1;
      bus_rw_q      <= 1'b1;
      bus_addr_q    <= '0;
      bus_wr_data_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rd_data_q <= '0;
    end else begin
      state_q       <= state_d;
      rw_q          <= rw_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cmd_ready_q   <= cmd_ready_d;
      bus_req_n_q   <= bus_req_n_d;
      bus_as_n_q    <= bus_as_n_d;
      bus_rw_q      <= bus_rw_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rd_data_q <= rsp_rd_data_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign cmd_ready   = cmd_ready_q;
  assign bus_req_    = bus_req_n_q;
  assign bus_as_     = bus_as_n_q;
  assign bus_rw      = bus_rw_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wr_data = bus_wr_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rd_data = rsp_rd_data_q;

endmodule

// File: tb/tb_bus_master_if.sv
// -----------------------------------------------------------------------------
// tb_bus_master_if
//   Self-checking bench for bus_master_if. Expected completions are queued
//   when a command is issued and compared when rsp_valid pulses. A negedge
//   monitor checks the address phase and bus stability on every cycle.
//   Define BUS_TIMEOUT_EN to include the timeout-abort scenario.
// -----------------------------------------------------------------------------
module tb_bus_master_if;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_rw = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wr_data = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rd_data;
  logic              rsp_err;
  logic              bus_req_;
  logic              bus_grnt_ = 1'b1;
  logic              bus_as_;
  logic              bus_rw;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data = '0;
  logic              bus_rdy_ = 1'b1;

  bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wr_data(cmd_wr_data),
    .rsp_valid(rsp_valid), .rsp_rd_data(rsp_rd_data), .rsp_err(rsp_err),
    .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_as_(bus_as_),
    .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [DATA_W-1:0] rd;
    logic              err;
  } exp_t;

  exp_t sb_q[$];

  // Current transaction, as the bench issued it.
  logic              cur_rw = 1'b1;
  logic [ADDR_W-1:0] cur_addr = '0;
  logic [DATA_W-1:0] cur_wd = '0;
  int                acc_cyc = 0;

  // Monitor state, written only by the monitor.
  int as_lo = 0;
  int req_pre = 0;
  int last_req_pre = 0;
  bit seen_as = 1'b0;
  bit rsp_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      as_lo = 0; req_pre = 0; seen_as = 1'b0; rsp_prev = 1'b0;
    end else begin
      if (!bus_as_) begin
        as_lo++;
        seen_as = 1'b1;
        chk("as_addr", 64'(bus_addr), 64'(cur_addr));
        chk("as_rw", 64'(bus_rw), 64'(cur_rw));
      end else if (!bus_req_ && !seen_as) begin
        req_pre++;
      end
      if (seen_as) begin
        chk("bus_addr_stable", 64'(bus_addr), 64'(cur_addr));
        if (!cur_rw) chk("wdata_stable", 64'(bus_wr_data), 64'(cur_wd));
      end
      if (rsp_valid) begin
        if (rsp_prev) chk("rsp_one_cycle", 64'(1), 64'(0));
        if (sb_q.size() == 0) begin
          chk("rsp_unexpected", 64'(1), 64'(0));
        end else begin
          e = sb_q.pop_front();
          chk("rsp_rd_data", 64'(rsp_rd_data), 64'(e.rd));
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          chk("as_pulse_len", 64'(as_lo), 64'(1));
          chk("req_hi_at_rsp", 64'(bus_req_), 64'(1));
        end
        last_req_pre = req_pre;
        as_lo = 0; req_pre = 0; seen_as = 1'b0;
      end
      rsp_prev = rsp_valid;
    end
  end

  // Issue one command; returns #1 after the accepting edge.
  task automatic issue(input logic rw, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wd, input bit push,
                       input logic [DATA_W-1:0] exp_rd, input logic exp_err);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("cmd_ready_wait", 64'(0), 64'(1));
    cur_rw = rw; cur_addr = addr; cur_wd = wd;
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_wr_data = wd;
    if (push) begin
      e.rd = exp_rd; e.err = exp_err;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for rsp_valid; lat = cycles since the accepting edge.
  task automatic wait_rsp(output int lat);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
    if (!rsp_valid) begin
      chk("rsp_wait_timeout", 64'(0), 64'(1));
      lat = -1;
    end else begin
      lat = cyc - acc_cyc;
    end
    #1;
  endtask

  logic [DATA_W-1:0] last_rd = '0;
  int lat;

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_bus_req", 64'(bus_req_), 64'(1));
    chk("rst_bus_as", 64'(bus_as_), 64'(1));
    chk("rst_bus_rw", 64'(bus_rw), 64'(1));
    chk("rst_bus_addr", 64'(bus_addr), 64'(0));
    chk("rst_bus_wd", 64'(bus_wr_data), 64'(0));
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_rd", 64'(rsp_rd_data), 64'(0));
    chk("rst_rsp_err", 64'(rsp_err), 64'(0));
    rst = 1'b1;

    // Idle for 10 cycles with no command
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", 64'({bus_req_, bus_as_, cmd_ready, rsp_valid}), 64'(4'b1110));
    end

    // Read 0x100, grant and ready already low: minimum latency
    bus_grnt_ = 1'b0; bus_rdy_ = 1'b0; bus_rd_data = 32'hDEADBEEF;
    issue(1'b1, 30'h100, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    last_rd = 32'hDEADBEEF;
    wait_rsp(lat);
    chk("rd_latency", 64'(lat), 64'(3));
    chk("rd_req_before_as", 64'(last_req_pre), 64'(1));

    // Back-to-back write: read data must hold its previous value
    bus_rd_data = 32'h11112222;
    issue(1'b0, 30'h44, 32'hA5A5_5A5A, 1'b1, last_rd, 1'b0);
    wait_rsp(lat);
    chk("wr_latency", 64'(lat), 64'(3));

    // Write 0x12345678 @0x20, grant delayed; stray commands while busy
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    issue(1'b0, 30'h20, 32'h12345678, 1'b1, last_rd, 1'b0);
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 30'h3FF; cmd_wr_data = 32'hFFFF0000;
    repeat (4) @(posedge clk);
    #1 bus_grnt_ = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus_rdy_ = 1'b0; cmd_valid = 1'b0;
    wait_rsp(lat);
    chk("gdly_latency", 64'(lat), 64'(9));
    chk("gdly_req_before_as", 64'(last_req_pre), 64'(5));

    // Ready pulsed during REQ is ignored; completion on 4th WAIT cycle
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = 32'hCAFEF00D;
    issue(1'b1, 30'h2A5, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0);
    last_rd = 32'hCAFEF00D;
    bus_rdy_ = 1'b0;
    @(posedge clk);
    #1 bus_rdy_ = 1'b1; bus_grnt_ = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus_rdy_ = 1'b0;
    wait_rsp(lat);
    chk("early_rdy_latency", 64'(lat), 64'(7));

    // Reset asserted during WAIT: abandon, no response
    bus_grnt_ = 1'b0; bus_rdy_ = 1'b1; bus_rd_data = 32'h77778888;
    issue(1'b1, 30'h155, 32'h0, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_bus_req", 64'(bus_req_), 64'(1));
    chk("arst_bus_as", 64'(bus_as_), 64'(1));
    chk("arst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("arst_rsp_valid", 64'(rsp_valid), 64'(0));
    last_rd = '0;
    bus_rdy_ = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Next command completes normally
    bus_rd_data = 32'h0BADF00D;
    issue(1'b1, 30'h3C, 32'h0, 1'b1, 32'h0BADF00D, 1'b0);
    last_rd = 32'h0BADF00D;
    wait_rsp(lat);
    chk("post_rst_latency", 64'(lat), 64'(3));

`ifdef BUS_TIMEOUT_EN
    // Ready stuck high: abort after 16 WAIT cycles with error and zero data
    bus_grnt_ = 1'b0; bus_rdy_ = 1'b1; bus_rd_data = 32'h55555555;
    issue(1'b1, 30'h99, 32'h0, 1'b1, 32'h0, 1'b1);
    last_rd = '0;
    wait_rsp(lat);
    chk("tmo_latency", 64'(lat), 64'(18));
    @(negedge clk);
    chk("tmo_req_released", 64'(bus_req_), 64'(1));
    bus_rdy_ = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/bus_master_if.md
BUS_MASTER_IF -- requirements
Module: bus_master_if

Interface
REQ-001 SHALL have parameter ADDR_W, default 30, word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, consecutive WAIT cycles before abort (used only with BUS_TIMEOUT_EN).
REQ-004 SHALL use one clock, clk, with asynchronous active-low reset rst; these are fixed.
REQ-005 Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- cmd_valid  in  1  core command request.
- cmd_ready  out  1  block can accept a command.
- cmd_rw  in  1  1 = read, 0 = write.
- cmd_addr  in  ADDR_W  command address.
- cmd_wr_data  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rd_data  out  DATA_W  read data.
- rsp_err  out  1  completion was a timeout abort.
- bus_req_  out  1  arbiter request, active-low.
- bus_grnt_  in  1  arbiter grant, active-low.
- bus_as_  out  1  address strobe, active-low.
- bus_rw  out  1  bus direction, 1 = read.
- bus_addr  out  ADDR_W  bus address.
- bus_wr_data  out  DATA_W  bus write data.
- bus_rd_data  in  DATA_W  slave read data.
- bus_rdy_  in  1  slave ready, active-low.

Function
REQ-006 SHALL implement the FSM states IDLE, REQ, ACCESS and WAIT; all outputs SHALL be registered.
REQ-007 IDLE: cmd_ready=1, bus_req_=1, bus_as_=1; on cmd_valid=1, latch rw/addr/wr_data and go to REQ.
REQ-008 REQ: bus_req_=0, cmd_ready=0; on sampling bus_grnt_=0, go to ACCESS; otherwise stay in REQ indefinitely.
REQ-009 ACCESS: lasts exactly 1 cycle; bus_as_=0; bus_rw/bus_addr/bus_wr_data driven from latched command; go to WAIT.
REQ-010 WAIT: bus_as_=1, bus_req_=0; bus_rw/bus_addr/bus_wr_data held stable; bus_grnt_ ignored.
REQ-011 In WAIT, on sampling bus_rdy_=0: rsp_valid=1 for exactly 1 cycle; for reads, rsp_rd_data=bus_rd_data captured at that edge; bus_req_=1; go to IDLE.
REQ-012 On writes, rsp_rd_data SHALL hold its previous value.
REQ-013 bus_rdy_ SHALL be sampled only in WAIT; a bus_rdy_=0 in REQ or ACCESS SHALL be ignored.
REQ-014 bus_req_ SHALL stay low continuously from REQ through the completing WAIT cycle.
REQ-015 Minimum latency: with bus_grnt_ and bus_rdy_ already low, rsp_valid SHALL rise 3 cycles after the command-accept edge.
REQ-016 bus_req_ SHALL be high in IDLE, so back-to-back commands produce a 1-cycle high gap on bus_req_.
REQ-017 cmd_valid SHALL be ignored while cmd_ready=0; there is no queueing.

Reset
REQ-018 rst=0 SHALL asynchronously force IDLE and set: bus_req_=1, bus_as_=1, bus_rw=1, bus_addr=0, bus_wr_data=0, cmd_ready=1, rsp_valid=0, rsp_rd_data=0, rsp_err=0, timeout counter=0.
REQ-019 Reset mid-transaction SHALL abandon the transaction with no rsp_valid.

Configuration
REQ-020 With BUS_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT and increment each WAIT cycle with bus_rdy_=1.
REQ-021 With BUS_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES: rsp_valid=1, rsp_err=1, rsp_rd_data=0, bus_req_=1, go to IDLE.
REQ-022 With BUS_TIMEOUT_EN defined, if bus_rdy_=0 on the same cycle the counter reaches TIMEOUT_CYCLES, normal completion SHALL win (rsp_err=0).
REQ-023 Without BUS_TIMEOUT_EN, rsp_err SHALL be tied 0, no counter SHALL exist, and WAIT SHALL persist until bus_rdy_=0.

Verification
REQ-024 Scenario: after reset, with no command for 10 cycles -> bus_req_=1, bus_as_=1, cmd_ready=1, rsp_valid=0 throughout.
REQ-025 Scenario: read addr 0x100, bus_grnt_ and bus_rdy_ tied 0, bus_rd_data=0xDEADBEEF -> bus_as_ low for 1 cycle with bus_addr=0x100 and bus_rw=1; rsp_valid 3 cycles after accept; rsp_rd_data=0xDEADBEEF.
REQ-026 Scenario: write 0x12345678 to addr 0x20, grant delayed 5 cycles -> bus_req_ low for 5 cycles before bus_as_; bus_wr_data=0x12345678 stable until bus_rdy_=0; rsp_err=0.
REQ-027 Scenario: bus_rdy_ pulsed 0 during REQ, then held 1 for 3 WAIT cycles, then 0 -> early pulse ignored; completion on the 4th WAIT cycle.
REQ-028 Scenario (BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16): bus_rdy_ stuck 1 -> rsp_valid=1, rsp_err=1, rsp_rd_data=0 after 16 WAIT cycles; bus_req_ returns to 1.
REQ-029 Scenario: rst asserted during WAIT -> bus_req_=1 and bus_as_=1 immediately (asynchronously); no rsp_valid; next command completes normally.
